// File: rtl/spoly_gen.sv
// Fixed-weight short polynomial generator: zero-fills P coefficients, then
// scatters W random +1/-1 values at distinct positions by rejection sampling.
module spoly_gen #(
    parameter int P        = 677,
    parameter int W        = 252,
    parameter int CW       = 13,
    parameter int AW       = 11,
    parameter int EXT_RAND = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [31:0]   seed,
    input  logic          rand_valid,
    input  logic [31:0]   rand_data,
    output logic          rand_ready,
    output logic          mem_we,
    output logic [AW-1:0] mem_address,
    output logic [CW-1:0] mem_input,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] weight_cnt,
    output logic [15:0]   reject_cnt
);
    localparam int              POSW         = $clog2(P);
    localparam logic [31:0]     DEFAULT_SEED = 32'd136987453;
    localparam logic [POSW:0]   P_LIM        = (POSW+1)'(P);
    localparam logic [AW-1:0]   LAST_ADDR    = AW'(P - 1);
    localparam logic [AW-1:0]   LAST_WEIGHT  = AW'(W - 1);

    typedef enum logic [1:0] {IDLE, CLEAR, PLACE, FIN} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [AW-1:0]   clr_addr;
    logic [P-1:0]    bitmap;
    logic [31:0]     lfsr;
    logic [31:0]     draw_word;
    logic [POSW-1:0] pos;
    logic            start_ok;
    logic            draw;
    logic            in_range;
    logic            accept;
    logic            last_clear;
    logic            last_accept;

    function automatic logic [31:0] xorshift32(input logic [31:0] x);
        logic [31:0] y;
        y = x ^ (x << 13);
        y = y ^ (y >> 17);
        y = y ^ (y << 5);
        return y;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)       state_nxt = CLEAR;
            CLEAR:   if (last_clear)  state_nxt = PLACE;
            PLACE:   if (last_accept) state_nxt = FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Draw decode: out-of-range positions are rejected before the bitmap is consulted.
    always_comb begin
        draw_word   = (EXT_RAND != 0) ? rand_data : lfsr;
        pos         = draw_word[POSW-1:0];
        start_ok    = (state == IDLE) && start;
        rand_ready  = (EXT_RAND != 0) && (state == PLACE);
        draw        = (state == PLACE) && ((EXT_RAND == 0) || rand_valid);
        in_range    = ({1'b0, pos} < P_LIM);
        accept      = draw && in_range && !bitmap[pos];
        last_clear  = (state == CLEAR) && (clr_addr == LAST_ADDR);
        last_accept = accept && (weight_cnt == LAST_WEIGHT);
        busy        = (state == CLEAR) || (state == PLACE);
        done        = (state == FIN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_addr    <= '0;
            bitmap      <= '0;
            lfsr        <= DEFAULT_SEED;
            mem_we      <= 1'b0;
            mem_address <= '0;
            mem_input   <= '0;
            weight_cnt  <= '0;
            reject_cnt  <= '0;
        end else begin
            mem_we <= 1'b0;
            if (start_ok) begin
                clr_addr   <= '0;
                bitmap     <= '0;
                weight_cnt <= '0;
                reject_cnt <= '0;
                lfsr       <= (seed == 32'd0) ? DEFAULT_SEED : seed;
            end
            if (state == CLEAR) begin
                mem_we      <= 1'b1;
                mem_address <= clr_addr;
                mem_input   <= '0;
                clr_addr    <= clr_addr + AW'(1);
            end
            if ((state == PLACE) && (EXT_RAND == 0)) begin
                lfsr <= xorshift32(lfsr);
            end
            if (accept) begin
                mem_we      <= 1'b1;
                mem_address <= AW'(pos);
                mem_input   <= draw_word[31] ? {CW{1'b1}} : CW'(1);
                bitmap[pos] <= 1'b1;
                weight_cnt  <= weight_cnt + AW'(1);
            end else if (draw && (reject_cnt != 16'hFFFF)) begin
                reject_cnt <= reject_cnt + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_spoly_gen.sv
// Bench for spoly_gen: three instances (internal P=677, external P=16 and P=10)
// checked against a reference model of clear-then-place rejection sampling.
module tb_spoly_gen;
    typedef struct packed {
        logic [10:0] addr;
        logic [12:0] data;
    } wr_t;

    int pl      [3] = '{677, 16, 10};
    int weights [3] = '{252, 4, 2};
    int posw    [3] = '{10, 4, 4};

    logic [31:0] words1 [5] = '{32'h00000003, 32'h80000003, 32'h8000000A, 32'h0000000F, 32'h00000000};
    logic [31:0] words2 [4] = '{32'h0000000C, 32'h0000000F, 32'h00000002, 32'h00000005};

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic        start0, start1, start2;
    logic [31:0] seed0, seed1, seed2;
    logic        rv0, rv1, rv2;
    logic [31:0] rd0, rd1, rd2;
    logic        rr0, rr1, rr2;
    logic        we0, we1, we2;
    logic [10:0] addr0, addr2;
    logic [4:0]  addr1;
    logic [12:0] din0, din1, din2;
    logic        busy0, busy1, busy2;
    logic        done0, done1, done2;
    logic [10:0] wc0, wc2;
    logic [4:0]  wc1;
    logic [15:0] rc0, rc1, rc2;

    spoly_gen #(.P(677), .W(252), .CW(13), .AW(11), .EXT_RAND(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .seed(seed0),
        .rand_valid(rv0), .rand_data(rd0), .rand_ready(rr0),
        .mem_we(we0), .mem_address(addr0), .mem_input(din0),
        .busy(busy0), .done(done0), .weight_cnt(wc0), .reject_cnt(rc0));

    spoly_gen #(.P(16), .W(4), .CW(13), .AW(5), .EXT_RAND(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .seed(seed1),
        .rand_valid(rv1), .rand_data(rd1), .rand_ready(rr1),
        .mem_we(we1), .mem_address(addr1), .mem_input(din1),
        .busy(busy1), .done(done1), .weight_cnt(wc1), .reject_cnt(rc1));

    spoly_gen #(.P(10), .W(2), .CW(13), .AW(11), .EXT_RAND(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .seed(seed2),
        .rand_valid(rv2), .rand_data(rd2), .rand_ready(rr2),
        .mem_we(we2), .mem_address(addr2), .mem_input(din2),
        .busy(busy2), .done(done2), .weight_cnt(wc2), .reject_cnt(rc2));

    int checks = 0;
    int errors = 0;
    int done_cnt [3] = '{0, 0, 0};
    int runs     [3] = '{0, 0, 0};
    int macc     [3];
    int mrej     [3];
    bit [2047:0] occ [3];
    wr_t q0[$], q1[$], q2[$];
    wr_t log0[$], log1[$], log2[$];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [31:0] xs(input logic [31:0] x);
        logic [31:0] y;
        y = x ^ (x << 13);
        y = y ^ (y >> 17);
        y = y ^ (y << 5);
        return y;
    endfunction

    function automatic int qsize(input int d);
        case (d)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic pushExp(input int d, input wr_t e);
        case (d)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    // Expected run: P zero writes in address order, then the accepted draws.
    task automatic modelReset(input int d);
        wr_t e;
        occ[d]  = '0;
        macc[d] = 0;
        mrej[d] = 0;
        case (d)
            0:       begin q0.delete(); log0.delete(); end
            1:       begin q1.delete(); log1.delete(); end
            default: begin q2.delete(); log2.delete(); end
        endcase
        for (int k = 0; k < pl[d]; k++) begin
            e.addr = 11'(k);
            e.data = 13'h0;
            pushExp(d, e);
        end
    endtask

    task automatic modelDraw(input int d, input logic [31:0] r);
        int  pos;
        wr_t e;
        pos = int'(r & ((32'd1 << posw[d]) - 32'd1));
        if (pos < pl[d] && !occ[d][pos]) begin
            occ[d][pos] = 1'b1;
            macc[d]++;
            e.addr = 11'(pos);
            e.data = r[31] ? 13'h1FFF : 13'h0001;
            pushExp(d, e);
        end else if (mrej[d] < 65535) begin
            mrej[d]++;
        end
    endtask

    task automatic modelInternal(input logic [31:0] s);
        logic [31:0] x;
        int guard;
        x = (s == 32'd0) ? 32'd136987453 : s;
        guard = 0;
        while (macc[0] < weights[0] && guard < 100000) begin
            modelDraw(0, x);
            x = xs(x);
            guard++;
        end
    endtask

    task automatic checkWrite(input int d, input logic [10:0] a, input logic [12:0] v);
        wr_t e;
        wr_t got;
        bit  have;
        have = 1'b0;
        e = '0;
        case (d)
            0:       if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
            1:       if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
            default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
        endcase
        if (!have) begin
            checks++;
            errors++;
            $display("[TB] FAIL d%0d_unexpected_write: got addr %0d data 0x%0h, required no write", d, a, v);
        end else begin
            checkOutput($sformatf("d%0d_wr_addr", d), 32'(a), 32'(e.addr));
            checkOutput($sformatf("d%0d_wr_data", d), 32'(v), 32'(e.data));
        end
        if (v != 13'h0) begin
            got.addr = a;
            got.data = v;
            case (d)
                0:       log0.push_back(got);
                1:       log1.push_back(got);
                default: log2.push_back(got);
            endcase
        end
    endtask

    task automatic checkDone(input int d, input logic b, input logic [10:0] wc, input logic [15:0] rc);
        done_cnt[d]++;
        checkOutput($sformatf("d%0d_busy_at_done", d), 32'(b), 32'd0);
        checkOutput($sformatf("d%0d_weight_at_done", d), 32'(wc), 32'(weights[d]));
        checkOutput($sformatf("d%0d_rejects_at_done", d), 32'(rc), 32'(mrej[d]));
        checkOutput($sformatf("d%0d_pending_writes", d), 32'(qsize(d)), 32'd0);
    endtask

    // Scoreboard: every write and every done pulse is checked as it appears.
    always @(negedge clk) begin
        if (rst_n) begin
            if (we0) checkWrite(0, addr0, din0);
            if (we1) checkWrite(1, {6'b0, addr1}, din1);
            if (we2) checkWrite(2, addr2, din2);
            if (done0) checkDone(0, busy0, wc0, rc0);
            if (done1) checkDone(1, busy1, {6'b0, wc1}, rc1);
            if (done2) checkDone(2, busy2, wc2, rc2);
        end
    end

    task automatic waitDone(input int d, input int budget);
        int n;
        n = 0;
        while (done_cnt[d] < runs[d] && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (done_cnt[d] < runs[d]) begin
            errors++;
            $display("[TB] FAIL d%0d_done_timeout: got %0d done pulses, required %0d", d, done_cnt[d], runs[d]);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] s);
        modelReset(0);
        modelInternal(s);
        runs[0]++;
        start0 = 1'b1;
        seed0  = s;
        tick();
        start0 = 1'b0;
    endtask

    task automatic checkLog0(input string tag);
        bit [2047:0] seen;
        int bad;
        seen = '0;
        bad  = 0;
        foreach (log0[i]) begin
            if (log0[i].addr >= 11'd677 || seen[log0[i].addr]) bad++;
            else seen[log0[i].addr] = 1'b1;
        end
        checkOutput({tag, "_nonzero_writes"}, 32'(log0.size()), 32'd252);
        checkOutput({tag, "_bad_addresses"}, 32'(bad), 32'd0);
        checkOutput({tag, "_weight_cnt"}, 32'(wc0), 32'd252);
    endtask

    task automatic checkLogEntry(input int d, input int i, input int a, input int v);
        wr_t e;
        e = '0;
        if (d == 0 && i < log0.size()) e = log0[i];
        if (d == 1 && i < log1.size()) e = log1[i];
        if (d == 2 && i < log2.size()) e = log2[i];
        checkOutput($sformatf("d%0d_place%0d_addr", d, i), 32'(e.addr), 32'(a));
        checkOutput($sformatf("d%0d_place%0d_data", d, i), 32'(e.data), 32'(v));
    endtask

    // Presents words with periodic valid gaps; a word is consumed when valid and ready met at an edge.
    task automatic feedWords(input int d, input int n);
        int idx;
        int guard;
        logic v;
        logic r;
        logic [31:0] w;
        idx = 0; guard = 0; v = 1'b0; r = 1'b0;
        while (idx < n && guard < 500) begin
            tick();
            guard++;
            if (v && r) idx++;
            v = (idx < n) && (guard % 3 != 0);
            w = 32'h0;
            if (idx < n) w = (d == 1) ? words1[idx] : words2[idx];
            r = (d == 1) ? rr1 : rr2;
            if (d == 1) begin rv1 = v; rd1 = w; end
            else        begin rv2 = v; rd2 = w; end
        end
        rv1 = 1'b0;
        rv2 = 1'b0;
        checkOutput($sformatf("d%0d_words_consumed", d), 32'(idx), 32'(n));
    endtask

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation still running, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int k;
        int guard;
        int cnt;
        rst_n = 1'b0;
        start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
        seed0 = 32'h0; seed1 = 32'h0; seed2 = 32'h0;
        rv0 = 1'b0; rv1 = 1'b0; rv2 = 1'b0;
        rd0 = 32'h0; rd1 = 32'h0; rd2 = 32'h0;
        repeat (3) tick();
        rst_n = 1'b1;
        #1;
        checkOutput("reset_mem_we", 32'(we0), 32'd0);
        checkOutput("reset_mem_address", 32'(addr0), 32'd0);
        checkOutput("reset_mem_input", 32'(din0), 32'd0);
        checkOutput("reset_busy", 32'(busy0), 32'd0);
        checkOutput("reset_done", 32'(done0), 32'd0);
        checkOutput("reset_weight_cnt", 32'(wc0), 32'd0);
        checkOutput("reset_reject_cnt", 32'(rc0), 32'd0);
        checkOutput("reset_rand_ready_int", 32'(rr0), 32'd0);
        checkOutput("reset_rand_ready_ext", 32'(rr1), 32'd0);

        cnt = 0;
        repeat (100) begin
            tick();
            if (we0 || busy0 || done0) cnt++;
        end
        checkOutput("idle_activity", 32'(cnt), 32'd0);

        checkOutput("model_xorshift_of_1", xs(32'd1), 32'h00042021);

        // Seed 1 run, with a start pulse in the middle of the clear sweep.
        modelReset(0);
        modelInternal(32'd1);
        runs[0]++;
        start0 = 1'b1;
        seed0  = 32'd1;
        checkOutput("busy_before_start", 32'(busy0), 32'd0);
        tick();
        start0 = 1'b0;
        checkOutput("busy_after_start", 32'(busy0), 32'd1);
        guard = 0;
        while (!we0 && guard < 10) begin
            tick();
            guard++;
        end
        checkOutput("first_clear_latency", 32'(guard), 32'd1);
        k = 0;
        while (we0 && din0 == 13'h0 && addr0 == 11'(k) && k < 2000) begin
            if (k == 300) begin
                start0 = 1'b1;
                seed0  = 32'd5;
            end else begin
                start0 = 1'b0;
            end
            k++;
            tick();
        end
        start0 = 1'b0;
        checkOutput("clear_run_length", 32'(k), 32'd677);
        waitDone(0, 5000);
        checkLog0("seed1");
        checkLogEntry(0, 0, 1, 1);
        checkLogEntry(0, 1, 33, 1);
        checkLogEntry(0, 2, 513, 1);

        applyStimulus(32'd0);
        waitDone(0, 5000);
        checkLog0("seed0");

        applyStimulus(32'd136987453);
        waitDone(0, 5000);
        checkLog0("seed_default");

        // Reset in the middle of placement, then a clean rerun.
        applyStimulus(32'd7);
        guard = 0;
        while (log0.size() < 20 && guard < 5000) begin
            tick();
            guard++;
        end
        checkOutput("placing_before_reset", 32'(busy0), 32'd1);
        checkOutput("rand_ready_internal", 32'(rr0), 32'd0);
        rst_n = 1'b0;
        #1;
        checkOutput("midrun_reset_mem_we", 32'(we0), 32'd0);
        checkOutput("midrun_reset_busy", 32'(busy0), 32'd0);
        checkOutput("midrun_reset_weight", 32'(wc0), 32'd0);
        q0.delete();
        runs[0]--;
        repeat (3) tick();
        rst_n = 1'b1;
        applyStimulus(32'd9);
        waitDone(0, 5000);
        checkLog0("after_reset");

        // External stream, P=16: stall first, then feed with valid gaps.
        modelReset(1);
        for (int i = 0; i < 5; i++) if (macc[1] < weights[1]) modelDraw(1, words1[i]);
        runs[1]++;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        repeat (60) tick();
        checkOutput("stall_busy", 32'(busy1), 32'd1);
        checkOutput("stall_rand_ready", 32'(rr1), 32'd1);
        checkOutput("stall_weight", 32'(wc1), 32'd0);
        checkOutput("stall_rejects", 32'(rc1), 32'd0);
        feedWords(1, 5);
        waitDone(1, 500);
        repeat (10) tick();
        checkOutput("p16_place_count", 32'(log1.size()), 32'd4);
        checkLogEntry(1, 0, 3, 1);
        checkLogEntry(1, 1, 10, 32'h1FFF);
        checkLogEntry(1, 2, 15, 1);
        checkLogEntry(1, 3, 0, 1);
        checkOutput("p16_reject_cnt", 32'(rc1), 32'd1);
        checkOutput("p16_weight_cnt", 32'(wc1), 32'd4);
        checkOutput("p16_done_pulses", 32'(done_cnt[1]), 32'd1);

        // External stream, P=10: positions 12 and 15 are out of range.
        modelReset(2);
        for (int i = 0; i < 4; i++) if (macc[2] < weights[2]) modelDraw(2, words2[i]);
        runs[2]++;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        feedWords(2, 4);
        waitDone(2, 500);
        repeat (5) tick();
        checkOutput("p10_place_count", 32'(log2.size()), 32'd2);
        checkLogEntry(2, 0, 2, 1);
        checkLogEntry(2, 1, 5, 1);
        checkOutput("p10_reject_cnt", 32'(rc2), 32'd2);
        checkOutput("p10_weight_cnt", 32'(wc2), 32'd2);
        checkOutput("p10_done_pulses", 32'(done_cnt[2]), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/spoly_gen.md
Name: spoly_gen

Overview:
- Parametrised fixed-weight short-polynomial generator for the sntrup datapath.
- Clears a P-entry coefficient memory, then places exactly W nonzero coefficients (+1/-1) at distinct random positions via rejection sampling.
- Randomness comes from either an internal seeded xorshift32 generator or an external valid/ready random-word stream, selected by parameter.
- Drives the external coefficient memory write port directly; sits between the seed/RNG source and the polynomial RAM.

Parameters:
- P, 677, polynomial length (number of coefficient addresses), 2..2047.
- W, 252, number of nonzero coefficients, 1 <= W <= P.
- CW, 13, coefficient word width; +1 = 1, -1 = all ones (two's complement).
- AW, 11, memory address width; P <= 2**AW.
- EXT_RAND, 0, 0 = internal xorshift32, 1 = external stream.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle request; sampled only in IDLE.
- seed  in  32  xorshift seed, latched on accepted start (ignored when EXT_RAND=1).
- rand_valid  in  1  external random word valid.
- rand_data  in  32  external random word.
- rand_ready  out  1  consume strobe for the external word; tied 0 when EXT_RAND=0.
- mem_we  out  1  registered write enable.
- mem_address  out  AW  registered write address.
- mem_input  out  CW  registered write data.
- busy  out  1  high from the cycle after accepted start until done.
- done  out  1  one-cycle pulse when generation is complete.
- weight_cnt  out  AW  nonzeros placed so far.
- reject_cnt  out  16  rejected draws in this run, saturating at 16'hFFFF.

Behaviour:
- Reset: state=IDLE. All outputs 0, occupancy bitmap (P bits) 0, LFSR = 32'd136987453.
- States: IDLE, CLEAR, PLACE, FIN.
- IDLE:
  - start=1 clears the bitmap, weight_cnt and reject_cnt.
  - Latches seed into the LFSR; seed==0 is replaced by 32'd136987453.
  - Moves to CLEAR with address counter 0. busy=1 next cycle.
- CLEAR:
  - One write per cycle: mem_we=1, mem_address=k, mem_input=0, for k=0..P-1.
  - After the k=P-1 write, go to PLACE.
  - Takes exactly P cycles.
- PLACE, per draw word r:
  - pos = r[POSW-1:0], where POSW = clog2(P); sign = r[31].
  - Accept if pos < P and bitmap[pos]==0:
    - mem_we=1, mem_address=pos, mem_input = sign ? all-ones : 1.
    - Set bitmap[pos]; increment weight_cnt.
  - Otherwise reject: mem_we=0; increment reject_cnt (saturating).
  - Internal mode: one draw per cycle. The LFSR advances every PLACE cycle (x^=x<<13; x^=x>>17; x^=x<<5), and the draw uses the pre-advance value.
  - External mode: rand_ready=1 combinationally while in PLACE. A draw occurs only on cycles with rand_valid&&rand_ready; otherwise no write and no counter change.
  - When the accept that makes weight_cnt==W is registered, go to FIN.
- FIN: mem_we=0, done=1 for one cycle, busy=0 the same cycle; return to IDLE.
- start while not IDLE is ignored.
- mem_we/mem_address/mem_input are registered: a write appears the cycle after its decision and is held valid for exactly one cycle.
- The last CLEAR write and the first PLACE write never overlap. Every address is written exactly once in CLEAR and at most once in PLACE.
- Reset mid-operation: immediate return to reset values, no further writes. Memory contents are undefined and regenerated on the next start.
- External mode with rand_valid held 0: the block stalls in PLACE indefinitely, busy=1. There is no timeout.

Test Plan:
- Reset/idle, P=677,W=252,EXT_RAND=0: hold rst_n=0 then release, no start -> all outputs 0, no mem_we for 100 cycles.
- Clear phase, P=677: start with seed=1 -> exactly 677 consecutive writes, addresses 0..676, data 0; busy rises 1 cycle after start.
- Small external case, P=16, W=4, EXT_RAND=1, AW=5, POSW=4:
  - Words: 0x00000003, 0x80000003 (duplicate -> reject), 0x8000000A, 0x0000000F, 0x00000000.
  - Required writes: addr 3 = 1, addr 10 = all ones, addr 15 = 1, addr 0 = 1.
  - reject_cnt=1, done pulses once, weight_cnt=4.
- Range rejection, P=10, W=2, EXT_RAND=1: words 0x0000000C, 0x0000000F, 0x00000002, 0x00000005 -> first two rejected (pos >= 10); writes at 2 and 5; reject_cnt=2.
- Internal mode: seed=0 vs seed=136987453 -> identical write sequences. The full run has exactly 252 nonzero writes, all distinct addresses < 677, and weight_cnt=252 at done.
- Robustness:
  - start pulsed mid-CLEAR -> ignored.
  - rst_n asserted mid-PLACE -> mem_we=0 and busy=0 immediately.
  - A following start produces a complete, correct run.
